// File: rtl/spi_rx_deserializer_pkg.sv
// Shared SPI definitions: bit-order encoding, rx FSM state encoding and the
// default word width used by the receive deserializer and its sub-modules.
package spi_pkg;

    localparam logic BIT_ORDER_MSB = 1'b0;
    localparam logic BIT_ORDER_LSB = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_LOAD  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_rx_deserializer_if.sv
// Valid/ready word interface between the SPI receive deserializer (master)
// and the register-side consumer (slave).
interface spi_rx_deserializer_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/spi_rx_shift_reg.sv
// Direction-selectable receive shift register with bit counter.
// word_next is the value the register takes on the current strobe, so the
// parent can capture a finished word on the same edge as the final bit.
module spi_rx_shift_reg
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cnt_clr,
    input  logic                  shift_en,
    input  logic                  lsb_first,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  last_bit,
    output logic                  cnt_nz
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] sr;
    logic [CNT_W-1:0]      cnt;

    // Next shift-register value for the selected bit order.
    always_comb begin
        word_next = lsb_first ? {miso, sr[DATA_WIDTH-1:1]}
                              : {sr[DATA_WIDTH-2:0], miso};
    end

    assign last_bit = (cnt == CNT_W'(DATA_WIDTH - 1));
    assign cnt_nz   = (cnt != '0);

    // Shift on each accepted strobe; counter wraps explicitly so non-power-of-2 widths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= word_next;
            cnt <= last_bit ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI receive deserializer: samples MISO on strobes, assembles words in
// MSB- or LSB-first order and presents them through a one-entry valid/ready
// holding register.
// Optional feature macro SPI_RX_OVERRUN_EN: when defined, a word completing
// while the holding register is full is dropped and a sticky overrun flag is
// raised; when undefined, the new word overwrites the held one.
module spi_rx_deserializer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  cs_active,
    input  logic                  sample_stb,
    input  logic                  miso,
    input  logic                  bit_order,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    spi_rx_deserializer_if.master rx_if
);

    rx_state_e state, state_nxt;

    logic                  order_q;
    logic                  order_latch;
    logic                  cnt_clr;
    logic                  shift_en;
    logic                  word_done;
    logic                  load_word;
    logic                  abort_err;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  last_bit;
    logic                  cnt_nz;

    spi_rx_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_clr   (cnt_clr),
        .shift_en  (shift_en),
        .lsb_first (order_q == BIT_ORDER_LSB),
        .miso      (miso),
        .word_next (word_next),
        .last_bit  (last_bit),
        .cnt_nz    (cnt_nz)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; losing cs/en mid-word takes priority over completing it.
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE: begin
                if (en && cs_active) state_nxt = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (!cs_active || !en)         state_nxt = RX_IDLE;
                else if (sample_stb && last_bit) state_nxt = RX_LOAD;
            end
            RX_LOAD: begin
                state_nxt = (cs_active && en) ? RX_SHIFT : RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // FSM outputs: strobes only count in SHIFT while the frame is still live.
    always_comb begin
        busy        = 1'b0;
        cnt_clr     = 1'b0;
        order_latch = 1'b0;
        shift_en    = 1'b0;
        word_done   = 1'b0;
        abort_err   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_clr     = 1'b1;
                order_latch = en && cs_active;
            end
            RX_SHIFT: begin
                busy = 1'b1;
                if (cs_active && en) begin
                    shift_en  = sample_stb;
                    word_done = sample_stb && last_bit;
                end else begin
                    abort_err = !cs_active && cnt_nz;
                end
            end
            default: ;
        endcase
    end

    // Bit order is frozen for the whole frame once it starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           order_q <= BIT_ORDER_MSB;
        else if (order_latch) order_q <= bit_order;
    end

    // Frame error is a single-cycle pulse following a mid-word chip-select drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= abort_err;
    end

`ifdef SPI_RX_OVERRUN_EN
    logic hold_blocked;
    assign hold_blocked = rx_if.rx_valid && !rx_if.rx_ready;
    assign load_word    = word_done && !hold_blocked;

    // Sticky overrun: set when a finished word is dropped, cleared by disabling the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         overrun <= 1'b0;
        else if (!en)                       overrun <= 1'b0;
        else if (word_done && hold_blocked) overrun <= 1'b1;
    end
`else
    assign load_word = word_done;
    assign overrun   = 1'b0;
`endif

    // Holding register: load wins over a same-cycle accept so rx_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
        end else if (load_word) begin
            rx_if.rx_data  <= word_next;
            rx_if.rx_valid <= 1'b1;
        end else if (rx_if.rx_valid && rx_if.rx_ready) begin
            rx_if.rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Self-checking bench for spi_rx_deserializer: directed vector table,
// hand-written abort/overrun/reset sequences, and randomized frames checked
// against a bit-position reference model.
module tb_spi_rx_deserializer;
    import spi_pkg::*;

    localparam int W = 32;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic en         = 1'b0;
    logic cs_active  = 1'b0;
    logic sample_stb = 1'b0;
    logic miso       = 1'b0;
    logic bit_order  = 1'b0;
    logic busy;
    logic frame_err;
    logic overrun;

    spi_rx_deserializer_if #(.DATA_WIDTH(W)) rx_if ();

    spi_rx_deserializer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cs_active  (cs_active),
        .sample_stb (sample_stb),
        .miso       (miso),
        .bit_order  (bit_order),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          order;
        logic [W-1:0]  stream;
        int            flip_after;
        logic [W-1:0]  exp_data;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic order);
        bit_order = order;
        en        = 1'b1;
        cs_active = 1'b1;
        tick();
    endtask

    task automatic end_frame();
        cs_active = 1'b0;
        tick();
        tick();
    endtask

    // Sends the bits of 'stream' MSB first (bit W-1 goes on the wire first),
    // with gap_n idle cycles before every strobe; returns just after the final
    // strobe edge. Toggles bit_order after strobe index flip_after.
    task automatic send_bits(input logic [W-1:0] stream, input int nbits,
                             input int flip_after, input int gap_n);
        for (int i = 0; i < nbits; i++) begin
            repeat (gap_n) tick();
            miso       = stream[W-1-i];
            sample_stb = 1'b1;
            tick();
            sample_stb = 1'b0;
            miso       = 1'b0;
            if (i == flip_after) bit_order = ~bit_order;
        end
    endtask

    // Reference model: the i-th bit on the wire lands at position W-1-i for
    // MSB-first frames and at position i for LSB-first frames.
    function automatic logic [W-1:0] model_word(input logic [W-1:0] stream, input logic lsb);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (lsb) r[i]       = stream[W-1-i];
            else     r[W-1-i]   = stream[W-1-i];
        end
        return r;
    endfunction

    initial begin
        logic [W-1:0] w;
        logic         ord;
        int           nwords;
        int           gap;
        int           flip;

        rx_if.rx_ready = 1'b0;

        vecs[0] = '{order: 1'b0, stream: 32'hA5C3_0F81, flip_after: -1, exp_data: 32'hA5C3_0F81};
        vecs[1] = '{order: 1'b1, stream: 32'hA5C3_0F81, flip_after: -1, exp_data: 32'h81F0_C3A5};
        vecs[2] = '{order: 1'b0, stream: 32'hA5C3_0F81, flip_after: 5,  exp_data: 32'hA5C3_0F81};

        // Reset state
        #12;
        check("reset_busy",      busy,           0);
        check("reset_rx_valid",  rx_if.rx_valid, 0);
        check("reset_rx_data",   rx_if.rx_data,  0);
        check("reset_frame_err", frame_err,      0);
        check("reset_overrun",   overrun,        0);
        rst_n = 1'b1;
        tick();

        // T1..T3 vector table
        for (int v = 0; v < 3; v++) begin
            start_frame(vecs[v].order);
            check($sformatf("vec%0d_busy", v), busy, 1);
            send_bits(vecs[v].stream, W - 1, vecs[v].flip_after, 1);
            check($sformatf("vec%0d_valid_early", v), rx_if.rx_valid, 0);
            repeat (1) tick();
            miso = vecs[v].stream[0];
            sample_stb = 1'b1;
            tick();
            sample_stb = 1'b0;
            check($sformatf("vec%0d_valid", v), rx_if.rx_valid, 1);
            check($sformatf("vec%0d_data", v),  rx_if.rx_data,  vecs[v].exp_data);
            tick();
            check($sformatf("vec%0d_hold", v), rx_if.rx_data, vecs[v].exp_data);
            rx_if.rx_ready = 1'b1;
            tick();
            rx_if.rx_ready = 1'b0;
            check($sformatf("vec%0d_accept", v), rx_if.rx_valid, 0);
            end_frame();
        end

        // T4 abort after 10 strobes
        start_frame(1'b0);
        send_bits(32'hFFFF_FFFF, 10, -1, 1);
        cs_active = 1'b0;
        tick();
        check("abort_frame_err", frame_err,      1);
        check("abort_busy",      busy,           0);
        check("abort_valid",     rx_if.rx_valid, 0);
        tick();
        check("abort_pulse_end", frame_err,      0);
        start_frame(1'b0);
        send_bits(32'hA5C3_0F81, W, -1, 1);
        check("abort_next_valid", rx_if.rx_valid, 1);
        check("abort_next_data",  rx_if.rx_data,  32'hA5C3_0F81);
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        end_frame();

        // T5 overrun: two words, holding register never drained
        start_frame(1'b0);
        send_bits(32'h1111_1111, W, -1, 1);
        check("ovr_first_data", rx_if.rx_data, 32'h1111_1111);
        send_bits(32'h2222_2222, W, -1, 2);
        check("ovr_valid", rx_if.rx_valid, 1);
`ifdef SPI_RX_OVERRUN_EN
        check("ovr_data",    rx_if.rx_data, 32'h1111_1111);
        check("ovr_flag",    overrun,       1);
        tick();
        check("ovr_sticky",  overrun,       1);
`else
        check("ovr_data",    rx_if.rx_data, 32'h2222_2222);
        check("ovr_flag",    overrun,       0);
`endif
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        end_frame();
        en = 1'b0;
        tick();
        check("ovr_clear_en", overrun, 0);

        // Simultaneous accept and load: new word loads, valid stays high, no overrun
        start_frame(1'b0);
        send_bits(32'h3333_3333, W, -1, 1);
        send_bits(32'h4444_4444, W - 1, -1, 1);
        tick();
        miso = 1'b0;
        rx_if.rx_ready = 1'b1;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        rx_if.rx_ready = 1'b0;
        check("simul_valid",   rx_if.rx_valid, 1);
        check("simul_data",    rx_if.rx_data,  32'h4444_4444);
        check("simul_overrun", overrun,        0);
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        end_frame();

        // T6 reset mid-word while a word is held
        start_frame(1'b1);
        send_bits(32'h1111_1111, W, -1, 1);
        send_bits(32'hFFFF_FFFF, 7, -1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy",      busy,           0);
        check("rst_valid",     rx_if.rx_valid, 0);
        check("rst_data",      rx_if.rx_data,  0);
        check("rst_frame_err", frame_err,      0);
        cs_active = 1'b0;
        tick();
        check("rst_frame_err_hold", frame_err, 0);
        rst_n = 1'b1;
        tick();
        start_frame(1'b0);
        send_bits(32'hDEAD_BEEF, W, -1, 1);
        check("rst_clean_valid", rx_if.rx_valid, 1);
        check("rst_clean_data",  rx_if.rx_data,  32'hDEAD_BEEF);
        rx_if.rx_ready = 1'b1;
        tick();
        end_frame();

        // Randomized frames against the reference model, consumer always ready
        rx_if.rx_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            ord    = 1'($urandom_range(0, 1));
            nwords = $urandom_range(1, 3);
            start_frame(ord);
            for (int k = 0; k < nwords; k++) begin
                w    = $urandom();
                gap  = $urandom_range(1, 3);
                flip = $urandom_range(0, 40);
                send_bits(w, W, flip, gap);
                check($sformatf("rand_f%0d_w%0d_valid", f, k), rx_if.rx_valid, 1);
                check($sformatf("rand_f%0d_w%0d_data", f, k),  rx_if.rx_data,  model_word(w, ord));
            end
            end_frame();
            check($sformatf("rand_f%0d_drained", f), rx_if.rx_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
